// File: rtl/mult_acc_pkg.sv
// Shared definitions for the mult_acc multiply-add/accumulate unit:
// op encodings and a latency helper for integrators and benches.
package mult_acc_pkg;

  // Operation select encodings.
  localparam logic [1:0] OP_ADD_C = 2'b00;  // p = c + a*b
  localparam logic [1:0] OP_SUB_C = 2'b01;  // p = c - a*b
  localparam logic [1:0] OP_ACC   = 2'b10;  // p = p + a*b
  localparam logic [1:0] OP_DEC   = 2'b11;  // p = p - a*b

  // Enabled cycles from in_valid sampled high to out_valid high.
  function automatic int mult_acc_latency(input int in_stages, input int m_stage);
    return in_stages + m_stage + 1;
  endfunction

endpackage

// File: rtl/mult_acc_pipe.sv
// Clock-enable gated delay line carrying a valid bit and a small data word.
// DEPTH=0 degenerates to a straight wire.
module mult_acc_pipe #(
  parameter int DEPTH = 1,
  parameter int W     = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         ce,
  input  logic         in_valid,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic [W-1:0] out_data
);

  generate
    if (DEPTH == 0) begin : g_wire
      assign out_valid = in_valid;
      assign out_data  = in_data;
    end else begin : g_regs
      logic [DEPTH-1:0]        valid_q, valid_d;
      logic [DEPTH-1:0][W-1:0] data_q, data_d;

      // Advance one stage per enabled cycle; everything holds while ce is low.
      always_comb begin
        // NOTE: every output of a combinational block gets a default first, so no path leaves it unassigned and no latch is inferred.
        valid_d = valid_q;
        data_d  = data_q;
        if (ce) begin
          valid_d[0] = in_valid;
          data_d[0]  = in_data;
          for (int i = 1; i < DEPTH; i++) begin
            valid_d[i] = valid_q[i-1];
            data_d[i]  = data_q[i-1];
          end
        end
      end

      // Stage registers; reset empties the line so in-flight beats are dropped.
      always_ff @(posedge clk or posedge rst) begin
        // NOTE: the data words are reset along with the valid bits only to keep them X-free; correctness relies on the valid bits alone.
        if (rst) begin
          // NOTE: state is written with non-blocking assignments so every flop samples pre-edge values regardless of block order.
          valid_q <= '0;
          data_q  <= '0;
        end else begin
          valid_q <= valid_d;
          data_q  <= data_d;
        end
      end

      assign out_valid = valid_q[DEPTH-1];
      assign out_data  = data_q[DEPTH-1];
    end
  endgenerate

endmodule

// File: rtl/mult_acc.sv
// Pipelined signed multiply-add/accumulate: p = c +/- a*b or p = p +/- a*b.
// Optional feature macro: MULT_ACC_SAT_EN (saturate p on overflow instead of wrapping).
// Legal configurations require P_W >= A_W+B_W, P_W >= C_W, IN_STAGES in 0..2.
module mult_acc
  import mult_acc_pkg::*;
#(
  parameter int A_W       = 18,
  parameter int B_W       = 18,
  parameter int C_W       = 36,
  parameter int P_W       = 48,
  parameter int IN_STAGES = 1,
  parameter int M_STAGE   = 0
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           ce,
  input  logic           in_valid,
  input  logic [1:0]     op,
  input  logic [A_W-1:0] a,
  input  logic [B_W-1:0] b,
  input  logic [C_W-1:0] c,
  output logic           out_valid,
  output logic [P_W-1:0] p,
  output logic           ovf
);

  localparam int PROD_W = A_W + B_W;
  localparam int OPD_W  = A_W + B_W + C_W;

  logic [OPD_W-1:0]         opd_s;
  logic signed [A_W-1:0]    a_s;
  logic signed [B_W-1:0]    b_s;
  logic signed [C_W-1:0]    c_s;
  logic signed [PROD_W-1:0] prod_s, prod_f;
  logic signed [C_W-1:0]    c_f;
  logic                     v_f;
  logic [1:0]               op_f;

  // Input operand stages (a, b, c packed together).
  generate
    if (IN_STAGES == 0) begin : g_in_comb
      assign opd_s = {a, b, c};
    end else begin : g_in_regs
      logic [IN_STAGES-1:0][OPD_W-1:0] opd_q, opd_d;

      // Shift operands one stage per enabled cycle.
      always_comb begin
        opd_d = opd_q;
        if (ce) begin
          opd_d[0] = {a, b, c};
          for (int i = 1; i < IN_STAGES; i++) opd_d[i] = opd_q[i-1];
        end
      end

      // Operand stage registers.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) opd_q <= '0;
        else     opd_q <= opd_d;
      end

      assign opd_s = opd_q[IN_STAGES-1];
    end
  endgenerate

  assign {a_s, b_s, c_s} = opd_s;
  assign prod_s = a_s * b_s;

  // Optional product register; c rides alongside to stay aligned with its product.
  generate
    if (M_STAGE == 0) begin : g_m_comb
      assign prod_f = prod_s;
      assign c_f    = c_s;
    end else begin : g_m_reg
      logic signed [PROD_W-1:0] prod_q, prod_d;
      logic signed [C_W-1:0]    c_m_q, c_m_d;

      // Capture the product on enabled cycles.
      always_comb begin
        prod_d = prod_q;
        c_m_d  = c_m_q;
        if (ce) begin
          prod_d = prod_s;
          c_m_d  = c_s;
        end
      end

      // Product stage registers.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          prod_q <= '0;
          c_m_q  <= '0;
        end else begin
          prod_q <= prod_d;
          c_m_q  <= c_m_d;
        end
      end

      assign prod_f = prod_q;
      assign c_f    = c_m_q;
    end
  endgenerate

  // valid and op travel with the operands through every stage.
  mult_acc_pipe #(
    .DEPTH (IN_STAGES + M_STAGE),
    .W     (2)
  ) u_pipe (
    .clk       (clk),
    .rst       (rst),
    .ce        (ce),
    .in_valid  (in_valid),
    .in_data   (op),
    .out_valid (v_f),
    .out_data  (op_f)
  );

  logic [P_W-1:0] p_q, p_d;
  logic           ovf_q, ovf_d;
  logic           out_valid_q, out_valid_d;
  logic [P_W:0]   addend, prod_x, sum;
  logic [P_W-1:0] res;
  logic           use_p, do_sub, sum_ovf;

  // P stage: one-bit-wide guard sum, overflow detect, optional saturation.
  always_comb begin
    use_p   = (op_f == OP_ACC) || (op_f == OP_DEC);
    do_sub  = (op_f == OP_SUB_C) || (op_f == OP_DEC);
    prod_x  = {{(P_W + 1 - PROD_W){prod_f[PROD_W-1]}}, prod_f};
    addend  = use_p ? {p_q[P_W-1], p_q} : {{(P_W + 1 - C_W){c_f[C_W-1]}}, c_f};
    sum     = do_sub ? (addend - prod_x) : (addend + prod_x);
    sum_ovf = sum[P_W] ^ sum[P_W-1];
`ifdef MULT_ACC_SAT_EN
    if (sum_ovf) res = sum[P_W] ? {1'b1, {(P_W-1){1'b0}}} : {1'b0, {(P_W-1){1'b1}}};
    else         res = sum[P_W-1:0];
`else
    res = sum[P_W-1:0];
`endif
  end

  // Result/flag update: only enabled cycles with a valid final-stage beat touch p and ovf.
  always_comb begin
    p_d         = p_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    if (ce) begin
      out_valid_d = v_f;
      if (v_f) begin
        p_d = res;
        if (sum_ovf)     ovf_d = 1'b1;
        else if (!use_p) ovf_d = 1'b0;
      end
    end
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p_q         <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      p_q         <= p_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign p         = p_q;
  assign ovf       = ovf_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mult_acc.sv
// Bench for mult_acc: six pipeline configurations share one stimulus stream;
// a sequential-fold model predicts every output each cycle, and directed
// literals pin the model. Honors MULT_ACC_SAT_EN when defined.
module tb_mult_acc;
  import mult_acc_pkg::*;

  localparam int     NCFG = 6;
  localparam int     HIST = 16384;
  localparam longint PMAX = (64'sd1 <<< 47) - 64'sd1;
  localparam longint PMIN = -(64'sd1 <<< 47);

  logic        clk = 1'b0;
  logic        rst, ce, in_valid;
  logic [1:0]  op;
  logic [17:0] a, b;
  logic [35:0] c;

  logic [NCFG-1:0] ov_w, ovf_w;
  logic [47:0]     p_w [NCFG];

  always #5 clk = ~clk;

  // Config k: IN_STAGES = k/2, M_STAGE = k%2. Config 2 is the default build.
  for (genvar k = 0; k < NCFG; k++) begin : g_dut
    mult_acc #(
      .A_W(18), .B_W(18), .C_W(36), .P_W(48),
      .IN_STAGES(k / 2), .M_STAGE(k % 2)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .ce        (ce),
      .in_valid  (in_valid),
      .op        (op),
      .a         (a),
      .b         (b),
      .c         (c),
      .out_valid (ov_w[k]),
      .p         (p_w[k]),
      .ovf       (ovf_w[k])
    );
  end

  int n_vec = 0;
  int n_bad = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  longint      m_acc  = 0;
  bit          m_ovf  = 0;
  bit          mv [HIST];
  logic [47:0] mp [HIST];
  bit          mo [HIST];
  int          ecnt   = 0;
  int          base   = 0;
  int          lat_ref [NCFG];
  bit          cur_ov  [NCFG];
  logic [47:0] cur_p   [NCFG];
  bit          cur_ovf [NCFG];
  bit          chk_en = 0;

  // Applies one beat to the running accumulator using plain integer arithmetic.
  task automatic model_beat(input logic [1:0] o, input logic signed [17:0] aa,
                            input logic signed [17:0] bb, input logic signed [35:0] cc,
                            output logic [47:0] r, output bit ov);
    longint prod, addend, sum;
    bit     of;
    prod   = longint'(aa) * longint'(bb);
    addend = o[1] ? m_acc : longint'(cc);
    sum    = o[0] ? addend - prod : addend + prod;
    of     = (sum > PMAX) || (sum < PMIN);
`ifdef MULT_ACC_SAT_EN
    if (of) sum = (sum > 0) ? PMAX : PMIN;
`else
    sum = (sum <<< 16) >>> 16;
`endif
    m_acc = sum;
    if (of)         m_ovf = 1'b1;
    else if (!o[1]) m_ovf = 1'b0;
    r  = sum[47:0];
    ov = m_ovf;
  endtask

  // Single compare process: advance the model on each enabled edge, then check all configs.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_acc = 0;
      m_ovf = 1'b0;
      base  = ecnt;
      for (int k = 0; k < NCFG; k++) begin
        cur_ov[k]  = 1'b0;
        cur_p[k]   = '0;
        cur_ovf[k] = 1'b0;
      end
    end else if (ce) begin
      if (in_valid) begin
        model_beat(op, a, b, c, mp[ecnt % HIST], mo[ecnt % HIST]);
        mv[ecnt % HIST] = 1'b1;
      end else begin
        mv[ecnt % HIST] = 1'b0;
      end
      for (int k = 0; k < NCFG; k++) begin
        int idx;
        idx = ecnt - lat_ref[k] + 1;
        if (idx >= base && mv[idx % HIST]) begin
          cur_ov[k]  = 1'b1;
          cur_p[k]   = mp[idx % HIST];
          cur_ovf[k] = mo[idx % HIST];
        end else begin
          cur_ov[k] = 1'b0;
        end
      end
      ecnt++;
    end
    #1;
    if (chk_en) begin
      for (int k = 0; k < NCFG; k++) begin
        check($sformatf("cfg%0d out_valid t=%0t", k, $time), ov_w[k], cur_ov[k]);
        check($sformatf("cfg%0d p t=%0t", k, $time), p_w[k], cur_p[k]);
        check($sformatf("cfg%0d ovf t=%0t", k, $time), ovf_w[k], cur_ovf[k]);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  typedef struct {
    bit          ce;
    bit          v;
    logic [1:0]  op;
    logic [17:0] a;
    logic [17:0] b;
    logic [35:0] c;
  } stim_t;

  stim_t       seq [$];
  logic [47:0] got_p [$];
  int          got_cyc [$];

  task automatic put(input bit ce_i, input bit v, input logic [1:0] o,
                     input logic [17:0] ai, input logic [17:0] bi, input logic [35:0] ci);
    @(negedge clk);
    ce = ce_i; in_valid = v; op = o; a = ai; b = bi; c = ci;
  endtask

  task automatic idle(input int n);
    repeat (n) put(1'b1, 1'b0, 2'b00, '0, '0, '0);
  endtask

  task automatic push(input bit ce_i, input bit v, input logic [1:0] o,
                      input logic [17:0] ai, input logic [17:0] bi, input logic [35:0] ci);
    stim_t s;
    s.ce = ce_i; s.v = v; s.op = o; s.a = ai; s.b = bi; s.c = ci;
    seq.push_back(s);
  endtask

  // Drives the queued sequence while collecting default-config results.
  task automatic run_seq();
    int n;
    n = seq.size();
    got_p.delete();
    got_cyc.delete();
    fork
      begin
        foreach (seq[i]) put(seq[i].ce, seq[i].v, seq[i].op, seq[i].a, seq[i].b, seq[i].c);
        idle(1);
      end
      begin
        for (int cyc = 0; cyc < n + 6; cyc++) begin
          @(posedge clk); #1;
          if (ce && ov_w[2]) begin
            got_p.push_back(p_w[2]);
            got_cyc.push_back(cyc);
          end
        end
      end
    join
    seq.delete();
  endtask

  // ---------------- directed + random tests ----------------
  logic [47:0] exp_acc [4];
  logic [47:0] exp_stall [4];
  logic [47:0] u_p [$];
  int          u_cyc [$];
  int          first_seen [NCFG];
  int          seen;

  initial begin
    for (int k = 0; k < NCFG; k++) lat_ref[k] = k / 2 + k % 2 + 1;
    rst = 1'b1; ce = 1'b1; in_valid = 1'b0; op = '0; a = '0; b = '0; c = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    check("reset p", p_w[2], 48'd0);
    check("reset out_valid", ov_w[2], 1'b0);
    check("reset ovf", ovf_w[2], 1'b0);
    chk_en = 1'b1;

    // Single beat: 100 + 3*(-5) = 85, visible exactly two cycles after presentation.
    put(1'b1, 1'b1, OP_ADD_C, 18'd3, -18'sd5, 36'd100);
    @(posedge clk); #1;
    check("t1 out_valid before latency", ov_w[2], 1'b0);
    idle(1);
    @(posedge clk); #1;
    check("t1 out_valid", ov_w[2], 1'b1);
    check("t1 p", p_w[2], 48'd85);
    idle(1);
    @(posedge clk); #1;
    check("t1 out_valid drops", ov_w[2], 1'b0);
    check("t1 p holds", p_w[2], 48'd85);

    // Accumulate chain 4, 5, 6, 7 on consecutive cycles.
    exp_acc = '{48'd4, 48'd5, 48'd6, 48'd7};
    push(1'b1, 1'b1, OP_ADD_C, 18'd2, 18'd2, 36'd0);
    repeat (3) push(1'b1, 1'b1, OP_ACC, 18'd1, 18'd1, 36'd0);
    run_seq();
    check("acc result count", got_p.size(), 4);
    for (int i = 0; i < got_p.size() && i < 4; i++) begin
      check($sformatf("acc p[%0d]", i), got_p[i], exp_acc[i]);
      if (i > 0) check($sformatf("acc spacing[%0d]", i), got_cyc[i] - got_cyc[i-1], 1);
    end

    // Stall: 31, 21, 5, 4 both unstalled and with ce low for 3 cycles mid-stream.
    exp_stall = '{48'd31, 48'd21, 48'd5, 48'd4};
    push(1'b1, 1'b1, OP_ADD_C, 18'd7, 18'd3, 36'd10);
    push(1'b1, 1'b1, OP_ACC, -18'sd2, 18'd5, 36'd0);
    push(1'b1, 1'b1, OP_DEC, 18'd4, 18'd4, 36'd0);
    push(1'b1, 1'b1, OP_ACC, 18'd1, -18'sd1, 36'd0);
    run_seq();
    u_p   = got_p;
    u_cyc = got_cyc;
    check("unstalled count", u_p.size(), 4);
    for (int i = 0; i < u_p.size() && i < 4; i++)
      check($sformatf("unstalled p[%0d]", i), u_p[i], exp_stall[i]);
    push(1'b1, 1'b1, OP_ADD_C, 18'd7, 18'd3, 36'd10);
    push(1'b1, 1'b1, OP_ACC, -18'sd2, 18'd5, 36'd0);
    repeat (3) push(1'b0, 1'b1, OP_DEC, 18'd4, 18'd4, 36'd0);
    push(1'b1, 1'b1, OP_DEC, 18'd4, 18'd4, 36'd0);
    push(1'b1, 1'b1, OP_ACC, 18'd1, -18'sd1, 36'd0);
    run_seq();
    check("stalled count", got_p.size(), 4);
    for (int i = 0; i < got_p.size() && i < 4 && i < u_p.size(); i++)
      check($sformatf("stalled p[%0d]", i), got_p[i], u_p[i]);
    if (got_cyc.size() == 4 && u_cyc.size() == 4)
      check("stall delay", got_cyc[3] - u_cyc[3], 3);

    // Overflow: c = 2^35-1 plus 2^34 per beat; beat 8189 lands exactly on 2^47-1.
    put(1'b1, 1'b1, OP_ADD_C, 18'h20000, 18'h20000, 36'h7_FFFF_FFFF);
    repeat (8189) put(1'b1, 1'b1, OP_ACC, 18'h20000, 18'h20000, 36'd0);
    idle(6);
    check("ovf edge p", p_w[2], 48'h7FFF_FFFF_FFFF);
    check("ovf edge flag", ovf_w[2], 1'b0);
    put(1'b1, 1'b1, OP_ACC, 18'h20000, 18'h20000, 36'd0);
    idle(6);
`ifdef MULT_ACC_SAT_EN
    check("ovf first p", p_w[2], 48'h7FFF_FFFF_FFFF);
`else
    check("ovf first p", p_w[2], 48'h8003_FFFF_FFFF);
`endif
    check("ovf first flag", ovf_w[2], 1'b1);
    put(1'b1, 1'b1, OP_ACC, 18'h20000, 18'h20000, 36'd0);
    idle(6);
`ifdef MULT_ACC_SAT_EN
    check("ovf second p", p_w[2], 48'h7FFF_FFFF_FFFF);
`else
    check("ovf second p", p_w[2], 48'h8007_FFFF_FFFF);
`endif
    check("ovf sticky", ovf_w[2], 1'b1);
    put(1'b1, 1'b1, OP_ADD_C, 18'd1, 18'd1, 36'd5);
    idle(6);
    check("ovf clear p", p_w[2], 48'd6);
    check("ovf cleared", ovf_w[2], 1'b0);

    // Asynchronous reset between edges with beats in flight.
    put(1'b1, 1'b1, OP_ADD_C, 18'd3, 18'd4, 36'd10);
    put(1'b1, 1'b1, OP_ACC, 18'd1, 18'd1, 36'd0);
    @(posedge clk); #3;
    rst = 1'b1;
    in_valid = 1'b0;
    #1;
    for (int k = 0; k < NCFG; k++) begin
      check($sformatf("cfg%0d async reset p", k), p_w[k], 48'd0);
      check($sformatf("cfg%0d async reset out_valid", k), ov_w[k], 1'b0);
      check($sformatf("cfg%0d async reset ovf", k), ovf_w[k], 1'b0);
    end
    @(negedge clk);
    rst = 1'b0;
    seen = 0;
    for (int cyc = 0; cyc < 8; cyc++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NCFG; k++) seen += int'(ov_w[k]);
    end
    check("no stale beat after reset", seen, 0);
    put(1'b1, 1'b1, OP_ACC, 18'd3, 18'd4, 36'd0);
    idle(6);
    check("first acc after reset", p_w[2], 48'd12);

    // Latency per configuration, measured from one isolated beat.
    for (int k = 0; k < NCFG; k++) first_seen[k] = 0;
    put(1'b1, 1'b1, OP_ADD_C, 18'd1, 18'd1, 36'd1);
    for (int cyc = 1; cyc <= 8; cyc++) begin
      @(posedge clk); #1;
      for (int k = 0; k < NCFG; k++)
        if (ov_w[k] && first_seen[k] == 0) first_seen[k] = cyc;
      if (cyc == 1) in_valid = 1'b0;
    end
    for (int k = 0; k < NCFG; k++) begin
      check($sformatf("cfg%0d measured latency", k), first_seen[k], lat_ref[k]);
      check($sformatf("cfg%0d latency function", k), mult_acc_latency(k / 2, k % 2), lat_ref[k]);
    end

    // Random stream with occasional stalls and bubbles across all configs.
    for (int i = 0; i < 400; i++)
      put($urandom_range(0, 9) != 0, $urandom_range(0, 3) != 0, 2'($urandom_range(0, 3)),
          18'($urandom), 18'($urandom), 36'({$urandom, $urandom}));
    idle(8);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
